fir_ctrl: RTL and testbench
===========================

# fir_ctrl

AXI-Lite configuration and sequencing controller for the FIR engine. It owns the ap_ctrl/status and data-length registers and the single port of the tap-coefficient BRAM. The port is shared between AXI-Lite coefficient access (when idle) and the engine's tap fetches (when busy). It starts the engine and records completion.

## Interface
- pADDR_WIDTH, 12, AXI-Lite and BRAM address width
- pDATA_WIDTH, 32, data width
- Tape_Num, 11, number of taps; tap window 0x20 .. 0x20+4*(Tape_Num-1)
- One clock; reset is asynchronous and active-low.
- axis_clk  in  1  clock
- axis_rst_n  in  1  async active-low reset
- awvalid/awready, wvalid/wready  in/out  1  AXI-Lite write handshakes; awaddr in 12, wdata in 32
- arvalid/arready  in/out  1  read-address handshake; araddr in 12
- rvalid out 1, rready in 1, rdata out 32  read data
- tap_WE out 4, tap_EN out 1, tap_Di out 32, tap_A out 12, tap_Do in 32  tap BRAM port
- eng_start  out  1  one-cycle start pulse to engine
- eng_tap_en  in  1  engine tap-read request (valid only while busy)
- eng_tap_idx  in  4  engine tap index 0..Tape_Num-1
- eng_done  in  1  one-cycle pulse: last output accepted downstream
- cfg_len  out  32  data-length register value

## Operation
- Register map: 0x00 ap_ctrl (bit0 ap_start, bit1 ap_done, bit2 ap_idle), 0x10 data_length, 0x20+4k tap k. Unmapped writes are dropped. Unmapped reads return 0.
- Control FSM: IDLE → START → BUSY → IDLE.
  - IDLE→START on a write to 0x00 with wdata[0]=1.
  - START: eng_start=1 for exactly one cycle; ap_start=1, ap_idle=0, ap_done=0.
  - START→BUSY unconditionally. ap_start clears on entry to BUSY.
  - BUSY→IDLE on eng_done; ap_done=1, ap_idle=1 on the same edge.
- Writes to 0x00 while not IDLE are dropped. Writes to 0x10 and to taps are accepted only in IDLE; otherwise they are dropped and still handshaken.
- ap_done clears on completion (rvalid&rready) of a read of 0x00.
- Tap port mux:
  - BUSY/START: tap_EN=eng_tap_en, tap_A=4*eng_tap_idx, tap_WE=0. The engine always wins.
  - IDLE: the AXI-Lite side drives tap_A=addr-0x20. A write uses tap_WE=4'hF and tap_Di=wdata.
- Tap reads while not IDLE return 32'hFFFF_FFFF without touching the BRAM.
- Same-cycle tap write and tap read in IDLE: the write takes the port and the read waits one cycle.

## Timing
- Reset values:
  - FSM IDLE, ap_idle=1, ap_start=0, ap_done=0, cfg_len=0.
  - awready=wready=arready=rvalid=0, rdata=0.
  - tap_EN=0, tap_WE=0, tap_A=0, tap_Di=0, eng_start=0.
- Reset mid-operation returns all state to these values immediately. The engine is not signalled.
- Write: awready and wready pulse together for one cycle, the cycle after awvalid&wvalid are both high. The register/BRAM write happens on that handshake edge. No response channel.
- Read FSM: R_IDLE → R_ADDR → R_WAIT → R_DATA.
  - arready pulses one cycle in R_ADDR.
  - R_WAIT drives the tap port (BRAM latency 1).
  - R_DATA holds rvalid=1 and rdata stable until rready.
  - rvalid rises exactly 2 cycles after the arready cycle for every address, plus 1 cycle per conflict stall.
- arvalid is ignored while the read FSM is not in R_IDLE.
- eng_done outside BUSY is ignored.

## Structure
- Shared package fir_pkg holds: register offsets (0x00, 0x10, 0x20), ap_ctrl bit positions, the busy-read pattern 32'hFFFF_FFFF, and control/read FSM state enums.
- One sub-module is natural: fir_tap_arb, the combinational tap-port mux with write-over-read priority.

## Test plan
- Reset then read 0x00 → rdata=0x4. Read 0x10 → 0.
- Write taps 0x20..0x48 with 0,-10,-9,23,56,63,56,23,-9,-10,0, then read them back → identical values. rvalid comes 2 cycles after arready.
- Write 0x10=600, then write 0x00=1 → one eng_start pulse. A 0x00 read during BUSY returns 0x0.
- During BUSY, write tap 0x24=99 and read 0x24 → read returns 0xFFFFFFFF. After done, 0x24 still reads -10.
- Pulse eng_done → 0x00 reads 0x6. A second read returns 0x4 (ap_done cleared).
- Assert axis_rst_n=0 in BUSY with eng_tap_en=1 → tap_EN=0 and ap_idle=1 immediately. A second start works normally.

Source files
------------

// File: rtl/fir_pkg.sv
// Shared constants and state encodings for the FIR configuration controller.
package fir_pkg;
  localparam int ADDR_W = 12;
  localparam int DATA_W = 32;

  localparam logic [11:0] REG_AP_CTRL  = 12'h000;
  localparam logic [11:0] REG_DATA_LEN = 12'h010;
  localparam logic [11:0] REG_TAP_BASE = 12'h020;

  localparam int AP_START_BIT = 0;
  localparam int AP_DONE_BIT  = 1;
  localparam int AP_IDLE_BIT  = 2;

  localparam logic [31:0] BUSY_RDATA = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {C_IDLE, C_START, C_BUSY} ctrl_state_t;
  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_WAIT, R_DATA} rd_state_t;
endpackage

// File: rtl/fir_if.sv
// AXI-Lite configuration bus (no write response channel).
interface fir_if #(
  parameter int AW = 12,
  parameter int DW = 32
);
  logic          awvalid, awready;
  logic [AW-1:0] awaddr;
  logic          wvalid, wready;
  logic [DW-1:0] wdata;
  logic          arvalid, arready;
  logic [AW-1:0] araddr;
  logic          rvalid, rready;
  logic [DW-1:0] rdata;

  modport master (
    output awvalid, awaddr, wvalid, wdata, arvalid, araddr, rready,
    input  awready, wready, arready, rvalid, rdata
  );
  modport slave (
    input  awvalid, awaddr, wvalid, wdata, arvalid, araddr, rready,
    output awready, wready, arready, rvalid, rdata
  );
endinterface

// File: rtl/fir_tap_arb.sv
// Tap BRAM port mux: engine owns the port outside IDLE; in IDLE a bus write
// beats a bus read, which is told to stall.
module fir_tap_arb #(
  parameter int AW = 12,
  parameter int DW = 32,
  parameter int IW = 4
) (
  input  logic          eng_own,
  input  logic          eng_en,
  input  logic [IW-1:0] eng_idx,
  input  logic          wr_go,
  input  logic [AW-1:0] wr_off,
  input  logic [DW-1:0] wr_data,
  input  logic          rd_go,
  input  logic [AW-1:0] rd_off,
  output logic          rd_stall,
  output logic [3:0]    tap_WE,
  output logic          tap_EN,
  output logic [DW-1:0] tap_Di,
  output logic [AW-1:0] tap_A
);
  always_comb begin
    tap_WE   = '0;
    tap_EN   = 1'b0;
    tap_Di   = '0;
    tap_A    = '0;
    rd_stall = 1'b0;
    if (eng_own) begin
      tap_EN = eng_en;
      tap_A  = AW'({eng_idx, 2'b00});
    end else if (wr_go) begin
      tap_EN   = 1'b1;
      tap_WE   = 4'hF;
      tap_Di   = wr_data;
      tap_A    = wr_off;
      rd_stall = rd_go;
    end else if (rd_go) begin
      tap_EN = 1'b1;
      tap_A  = rd_off;
    end
  end
endmodule

// File: rtl/fir_ctrl.sv
// FIR controller: AXI-Lite register file, start/done sequencing and
// sharing of the tap coefficient BRAM between the bus and the engine.
module fir_ctrl
  import fir_pkg::*;
#(
  parameter int pADDR_WIDTH = 12,
  parameter int pDATA_WIDTH = 32,
  parameter int Tape_Num    = 11
) (
  input  logic                   axis_clk,
  input  logic                   axis_rst_n,
  fir_if.slave                   axil,
  output logic [3:0]             tap_WE,
  output logic                   tap_EN,
  output logic [pDATA_WIDTH-1:0] tap_Di,
  output logic [pADDR_WIDTH-1:0] tap_A,
  input  logic [pDATA_WIDTH-1:0] tap_Do,
  output logic                   eng_start,
  input  logic                   eng_tap_en,
  input  logic [3:0]             eng_tap_idx,
  input  logic                   eng_done,
  output logic [pDATA_WIDTH-1:0] cfg_len
);
  localparam logic [pADDR_WIDTH-1:0] AP_A   = pADDR_WIDTH'(REG_AP_CTRL);
  localparam logic [pADDR_WIDTH-1:0] LEN_A  = pADDR_WIDTH'(REG_DATA_LEN);
  localparam logic [pADDR_WIDTH-1:0] TAP_LO = pADDR_WIDTH'(REG_TAP_BASE);
  localparam logic [pADDR_WIDTH-1:0] TAP_HI =
    pADDR_WIDTH'(32'(REG_TAP_BASE) + 32'(4 * (Tape_Num - 1)));

  function automatic logic tap_hit(input logic [pADDR_WIDTH-1:0] a);
    return (a >= TAP_LO) && (a <= TAP_HI) && (a[1:0] == 2'b00);
  endfunction

  ctrl_state_t cst, cst_nx;
  rd_state_t   rst, rst_nx;
  logic                   wr_rdy, ap_done, rd_bram, rd_stall;
  logic                   idle, wr_go, rd_go, rd_done;
  logic [pADDR_WIDTH-1:0] rd_addr;
  logic [pDATA_WIDTH-1:0] rdata_q, len_q, ap_word, rd_reg;

  assign idle    = (cst == C_IDLE);
  assign wr_go   = wr_rdy && idle && tap_hit(axil.awaddr);
  assign rd_go   = (rst == R_WAIT) && idle && tap_hit(rd_addr);
  assign rd_done = (rst == R_DATA) && axil.rready;
  assign cfg_len = len_q;

  // Control FSM
  always_ff @(posedge axis_clk or negedge axis_rst_n)
    if (!axis_rst_n) cst <= C_IDLE;
    else             cst <= cst_nx;

  always_comb begin
    cst_nx    = cst;
    eng_start = 1'b0;
    case (cst)
      C_IDLE:  if (wr_rdy && axil.awaddr == AP_A && axil.wdata[AP_START_BIT]) cst_nx = C_START;
      C_START: begin eng_start = 1'b1; cst_nx = C_BUSY; end
      C_BUSY:  if (eng_done) cst_nx = C_IDLE;
      default: cst_nx = C_IDLE;
    endcase
  end

  always_comb begin
    ap_word               = '0;
    ap_word[AP_START_BIT] = (cst == C_START);
    ap_word[AP_DONE_BIT]  = ap_done;
    ap_word[AP_IDLE_BIT]  = idle;
  end

  // Write channel: one-cycle ready pulse; the store happens on that edge.
  always_ff @(posedge axis_clk or negedge axis_rst_n)
    if (!axis_rst_n) begin
      wr_rdy  <= 1'b0;
      len_q   <= '0;
      ap_done <= 1'b0;
    end else begin
      wr_rdy <= axil.awvalid && axil.wvalid && !wr_rdy;
      if (wr_rdy && idle && axil.awaddr == LEN_A) len_q <= axil.wdata;
      if (cst == C_BUSY && eng_done)              ap_done <= 1'b1;
      else if (cst == C_START)                    ap_done <= 1'b0;
      else if (rd_done && rd_addr == AP_A)        ap_done <= 1'b0;
    end

  assign axil.awready = wr_rdy;
  assign axil.wready  = wr_rdy;

  // Read FSM
  always_ff @(posedge axis_clk or negedge axis_rst_n)
    if (!axis_rst_n) rst <= R_IDLE;
    else             rst <= rst_nx;

  always_comb begin
    rst_nx = rst;
    case (rst)
      R_IDLE:  if (axil.arvalid) rst_nx = R_ADDR;
      R_ADDR:  rst_nx = R_WAIT;
      R_WAIT:  if (!rd_stall) rst_nx = R_DATA;
      R_DATA:  if (axil.rready) rst_nx = R_IDLE;
      default: rst_nx = R_IDLE;
    endcase
  end

  always_comb begin
    rd_reg = '0;
    if (rd_addr == AP_A)       rd_reg = ap_word;
    else if (rd_addr == LEN_A) rd_reg = len_q;
    else if (tap_hit(rd_addr)) rd_reg = pDATA_WIDTH'(BUSY_RDATA);
  end

  // BRAM data appears the first R_DATA cycle; it is captured then so
  // rdata stays stable even if the engine later reuses the port.
  always_ff @(posedge axis_clk or negedge axis_rst_n)
    if (!axis_rst_n) begin
      rd_addr <= '0;
      rdata_q <= '0;
      rd_bram <= 1'b0;
    end else begin
      if (rst == R_ADDR) rd_addr <= axil.araddr;
      if (rst == R_WAIT && !rd_stall) begin
        rd_bram <= rd_go;
        rdata_q <= rd_reg;
      end else if (rst == R_DATA && rd_bram) begin
        rd_bram <= 1'b0;
        rdata_q <= tap_Do;
      end
    end

  assign axil.arready = (rst == R_ADDR);
  assign axil.rvalid  = (rst == R_DATA);
  assign axil.rdata   = (rst == R_DATA) ? (rd_bram ? tap_Do : rdata_q) : '0;

  fir_tap_arb #(.AW(pADDR_WIDTH), .DW(pDATA_WIDTH), .IW(4)) u_arb (
    .eng_own (!idle),
    .eng_en  (eng_tap_en),
    .eng_idx (eng_tap_idx),
    .wr_go   (wr_go),
    .wr_off  (axil.awaddr - TAP_LO),
    .wr_data (axil.wdata),
    .rd_go   (rd_go),
    .rd_off  (rd_addr - TAP_LO),
    .rd_stall(rd_stall),
    .tap_WE  (tap_WE),
    .tap_EN  (tap_EN),
    .tap_Di  (tap_Di),
    .tap_A   (tap_A)
  );
endmodule

// File: tb/tb_fir_ctrl.sv
// Bench for fir_ctrl: BRAM model, register-map reference model, scenario tasks.
module tb_fir_ctrl;
  logic axis_clk = 1'b0;
  logic axis_rst_n = 1'b0;
  always #5 axis_clk = ~axis_clk;

  fir_if #(.AW(12), .DW(32)) axil();
  logic [3:0]  tap_WE;
  logic        tap_EN;
  logic [31:0] tap_Di, tap_Do, cfg_len;
  logic [11:0] tap_A;
  logic        eng_start, eng_tap_en, eng_done;
  logic [3:0]  eng_tap_idx;

  fir_ctrl #(.pADDR_WIDTH(12), .pDATA_WIDTH(32), .Tape_Num(11)) dut (
    .axis_clk(axis_clk), .axis_rst_n(axis_rst_n), .axil(axil),
    .tap_WE(tap_WE), .tap_EN(tap_EN), .tap_Di(tap_Di), .tap_A(tap_A), .tap_Do(tap_Do),
    .eng_start(eng_start), .eng_tap_en(eng_tap_en), .eng_tap_idx(eng_tap_idx),
    .eng_done(eng_done), .cfg_len(cfg_len)
  );

  logic [31:0] bram [0:15];
  always @(posedge axis_clk)
    if (tap_EN) begin
      if (tap_WE == 4'hF) bram[tap_A[5:2]] <= tap_Di;
      tap_Do <= bram[tap_A[5:2]];
    end

  int starts = 0;
  always @(posedge axis_clk) if (eng_start === 1'b1) starts <= starts + 1;

  int vec = 0, errs = 0;

  // Reference model of the register map
  int          ref_tap [11];
  logic [31:0] ref_len;
  bit          ref_busy, ref_done;
  int          spec_taps [11] = '{0, -10, -9, 23, 56, 63, 56, 23, -9, -10, 0};

  function automatic bit is_tap(input logic [11:0] a);
    return a >= 12'h020 && a <= 12'h048 && a[1:0] == 2'b00;
  endfunction

  function automatic logic [31:0] ref_read(input logic [11:0] a);
    if (a == 12'h000) return ref_busy ? 32'h0 : {29'b0, 1'b1, ref_done, 1'b0};
    if (a == 12'h010) return ref_len;
    if (is_tap(a))    return ref_busy ? 32'hFFFF_FFFF : 32'(ref_tap[int'(a - 12'h020) / 4]);
    return 32'h0;
  endfunction

  function automatic void ref_write(input logic [11:0] a, input logic [31:0] d);
    if (ref_busy) return;
    if (a == 12'h000) begin
      if (d[0]) begin ref_busy = 1'b1; ref_done = 1'b0; end
    end else if (a == 12'h010) ref_len = d;
    else if (is_tap(a)) ref_tap[int'(a - 12'h020) / 4] = int'(d);
  endfunction

  function automatic void ref_reset();
    ref_busy = 1'b0; ref_done = 1'b0; ref_len = '0;
  endfunction

  task automatic axil_write(input logic [11:0] a, input logic [31:0] d);
    bit got = 1'b0;
    @(negedge axis_clk);
    axil.awaddr = a; axil.wdata = d; axil.awvalid = 1'b1; axil.wvalid = 1'b1;
    for (int i = 0; i < 8 && !got; i++) begin
      @(negedge axis_clk);
      got = axil.awready && axil.wready;
    end
    vec++;
    if (!got) begin errs++; $display("FAIL wr_handshake addr=%h ready never seen", a); end
    @(posedge axis_clk); #1;
    axil.awvalid = 1'b0; axil.wvalid = 1'b0;
    ref_write(a, d);
  endtask

  // lat = cycles from the arready cycle to the first rvalid cycle
  task automatic axil_read(input logic [11:0] a, input int hold,
                           output logic [31:0] d, output int lat);
    bit got = 1'b0;
    @(negedge axis_clk);
    axil.araddr = a; axil.arvalid = 1'b1; axil.rready = (hold == 0);
    for (int i = 0; i < 8 && !got; i++) begin
      @(negedge axis_clk);
      got = axil.arready;
    end
    if (!got) begin
      vec++; errs++; $display("FAIL rd_arready addr=%h never seen", a);
      axil.arvalid = 1'b0; axil.rready = 1'b0; d = 32'hDEAD_BEEF; lat = -1;
      return;
    end
    @(posedge axis_clk); #1;
    axil.arvalid = 1'b0;
    lat = 1; got = 1'b0;
    for (int i = 0; i < 8 && !got; i++) begin
      @(negedge axis_clk);
      got = axil.rvalid;
      if (!got) lat++;
    end
    if (!got) begin
      vec++; errs++; $display("FAIL rd_rvalid addr=%h never seen", a);
      axil.rready = 1'b0; d = 32'hDEAD_BEEF; lat = -1;
      return;
    end
    d = axil.rdata;
    for (int h = 0; h < hold; h++) begin
      @(negedge axis_clk);
      vec++;
      if (axil.rvalid !== 1'b1 || axil.rdata !== d) begin
        errs++; $display("FAIL rd_hold addr=%h rvalid=%b rdata=%h want %h", a, axil.rvalid, axil.rdata, d);
      end
    end
    axil.rready = 1'b1;
    @(posedge axis_clk); #1;
    axil.rready = 1'b0;
    if (a == 12'h000) ref_done = 1'b0;
  endtask

  task automatic pulse_done();
    @(negedge axis_clk); eng_done = 1'b1;
    @(negedge axis_clk); eng_done = 1'b0;
    if (ref_busy) begin ref_busy = 1'b0; ref_done = 1'b1; end
  endtask

  task automatic test_reset();
    logic [11:0] addrs [4] = '{12'h000, 12'h010, 12'h014, 12'hFFC};
    logic [31:0] d, exp;
    int lat;
    axis_rst_n = 1'b0; ref_reset();
    repeat (2) @(negedge axis_clk);
    vec++;
    if ({tap_EN, tap_WE, tap_A, tap_Di, eng_start} !== '0) begin
      errs++; $display("FAIL rst_tap EN=%b WE=%h A=%h Di=%h start=%b want all 0", tap_EN, tap_WE, tap_A, tap_Di, eng_start);
    end
    vec++;
    if ({axil.awready, axil.wready, axil.arready, axil.rvalid, axil.rdata} !== '0) begin
      errs++; $display("FAIL rst_bus aw=%b w=%b ar=%b rv=%b rdata=%h want 0", axil.awready, axil.wready, axil.arready, axil.rvalid, axil.rdata);
    end
    vec++;
    if (cfg_len !== 32'h0) begin errs++; $display("FAIL rst_len got=%h want 0", cfg_len); end
    @(negedge axis_clk); axis_rst_n = 1'b1;
    foreach (addrs[i]) begin
      exp = ref_read(addrs[i]);
      axil_read(addrs[i], 0, d, lat);
      vec++;
      if (d !== exp) begin errs++; $display("FAIL rst_read addr=%h got=%h want=%h", addrs[i], d, exp); end
    end
  endtask

  task automatic test_taps();
    logic [31:0] d, exp;
    int lat, k;
    for (int pass = 0; pass < 2; pass++) begin
      for (int i = 0; i < 11; i++)
        axil_write(12'h020 + 12'(4 * i), pass == 0 ? $urandom : 32'(spec_taps[i]));
      axil_write(12'h04C, $urandom);
      axil_write(12'h022, $urandom);
      for (int j = 0; j < 11; j++) begin
        k = (pass == 0) ? int'($urandom_range(0, 10)) : j;
        exp = ref_read(12'h020 + 12'(4 * k));
        axil_read(12'h020 + 12'(4 * k), pass == 0 ? int'($urandom_range(0, 2)) : 0, d, lat);
        vec++;
        if (d !== exp) begin errs++; $display("FAIL tap_read k=%0d got=%h want=%h", k, d, exp); end
        vec++;
        if (lat !== 2) begin errs++; $display("FAIL tap_lat k=%0d got=%0d want=2", k, lat); end
      end
    end
    axil_read(12'h04C, 0, d, lat);
    vec++;
    if (d !== 32'h0 || bram[11] !== 32'h0) begin
      errs++; $display("FAIL unmapped_tap rdata=%h bram11=%h want 0", d, bram[11]);
    end
  endtask

  task automatic test_conflict();
    logic [31:0] d, d2, exp, v;
    int lat, lat2;
    v = $urandom;
    exp = ref_read(12'h028);
    fork
      axil_read(12'h028, 0, d, lat);
      begin @(negedge axis_clk); axil_write(12'h03C, v); end
    join
    vec++;
    if (d !== exp) begin errs++; $display("FAIL conflict_data got=%h want=%h", d, exp); end
    vec++;
    if (lat !== 3) begin errs++; $display("FAIL conflict_lat got=%0d want=3", lat); end
    axil_read(12'h03C, 0, d2, lat2);
    vec++;
    if (d2 !== v) begin errs++; $display("FAIL conflict_wr got=%h want=%h", d2, v); end
    exp = ref_read(12'h02C);
    fork
      axil_read(12'h02C, 0, d, lat);
      begin @(negedge axis_clk); axil_write(12'h010, 32'd5); end
    join
    vec++;
    if (d !== exp || lat !== 2) begin
      errs++; $display("FAIL nonconflict got=%h lat=%0d want=%h lat=2", d, lat, exp);
    end
  endtask

  task automatic test_run();
    logic [31:0] d, exp;
    int lat, s0, k;
    axil_write(12'h010, 32'd600);
    vec++;
    if (cfg_len !== 32'd600) begin errs++; $display("FAIL len got=%0d want=600", cfg_len); end
    s0 = starts;
    axil_write(12'h000, 32'h0);
    repeat (2) @(negedge axis_clk);
    vec++;
    if (starts !== s0) begin errs++; $display("FAIL start_zero pulses=%0d want 0", starts - s0); end
    axil_write(12'h000, 32'h1);
    repeat (3) @(negedge axis_clk);
    vec++;
    if (starts - s0 !== 1) begin errs++; $display("FAIL start_pulse pulses=%0d want 1", starts - s0); end
    axil_read(12'h000, 0, d, lat);
    vec++;
    if (d !== 32'h0) begin errs++; $display("FAIL busy_ctrl got=%h want=0", d); end
    axil_write(12'h010, 32'd7);
    axil_write(12'h000, 32'h1);
    repeat (2) @(negedge axis_clk);
    vec++;
    if (cfg_len !== 32'd600 || starts - s0 !== 1) begin
      errs++; $display("FAIL busy_drop len=%0d pulses=%0d want 600,1", cfg_len, starts - s0);
    end
    axil_write(12'h024, 32'd99);
    exp = ref_read(12'h024);
    axil_read(12'h024, 0, d, lat);
    vec++;
    if (d !== exp) begin errs++; $display("FAIL busy_tap got=%h want=%h", d, exp); end
    for (int i = 0; i < 4; i++) begin
      k = int'($urandom_range(0, 10));
      @(negedge axis_clk); eng_tap_en = 1'b1; eng_tap_idx = 4'(k);
      #1;
      vec++;
      if (tap_EN !== 1'b1 || tap_A !== 12'(4 * k) || tap_WE !== 4'h0) begin
        errs++; $display("FAIL eng_port EN=%b A=%h WE=%h want 1,%h,0", tap_EN, tap_A, tap_WE, 12'(4 * k));
      end
      @(posedge axis_clk); #1;
      vec++;
      if (tap_Do !== 32'(ref_tap[k])) begin errs++; $display("FAIL eng_fetch k=%0d got=%h want=%h", k, tap_Do, 32'(ref_tap[k])); end
    end
    eng_tap_en = 1'b0;
    pulse_done();
    for (int r = 0; r < 2; r++) begin
      exp = ref_read(12'h000);
      axil_read(12'h000, 0, d, lat);
      vec++;
      if (d !== exp) begin errs++; $display("FAIL done_read%0d got=%h want=%h", r, d, exp); end
    end
    exp = ref_read(12'h024);
    axil_read(12'h024, 0, d, lat);
    vec++;
    if (d !== exp) begin errs++; $display("FAIL tap_kept got=%h want=%h", d, exp); end
    pulse_done();
    @(negedge axis_clk); eng_tap_en = 1'b1; eng_tap_idx = 4'd2;
    #1;
    vec++;
    if (tap_EN !== 1'b0) begin errs++; $display("FAIL idle_eng_en got=%b want=0", tap_EN); end
    eng_tap_en = 1'b0;
    axil_read(12'h000, 0, d, lat);
    vec++;
    if (d !== 32'h4) begin errs++; $display("FAIL stray_done got=%h want=4", d); end
  endtask

  task automatic test_reset_busy();
    logic [31:0] d, exp;
    int lat, s0;
    axil_write(12'h000, 32'h1);
    @(negedge axis_clk); eng_tap_en = 1'b1; eng_tap_idx = 4'd3;
    #1;
    vec++;
    if (tap_EN !== 1'b1) begin errs++; $display("FAIL pre_rst_en got=%b want=1", tap_EN); end
    axis_rst_n = 1'b0; ref_reset();
    #1;
    vec++;
    if (tap_EN !== 1'b0 || tap_A !== 12'h0 || eng_start !== 1'b0 || cfg_len !== 32'h0) begin
      errs++; $display("FAIL mid_rst EN=%b A=%h start=%b len=%h want 0", tap_EN, tap_A, eng_start, cfg_len);
    end
    @(negedge axis_clk); axis_rst_n = 1'b1; eng_tap_en = 1'b0;
    axil_read(12'h000, 0, d, lat);
    vec++;
    if (d !== 32'h4) begin errs++; $display("FAIL post_rst_ctrl got=%h want=4", d); end
    s0 = starts;
    axil_write(12'h000, 32'h1);
    repeat (3) @(negedge axis_clk);
    vec++;
    if (starts - s0 !== 1) begin errs++; $display("FAIL restart pulses=%0d want 1", starts - s0); end
    pulse_done();
    exp = ref_read(12'h000);
    axil_read(12'h000, 0, d, lat);
    vec++;
    if (d !== exp) begin errs++; $display("FAIL restart_done got=%h want=%h", d, exp); end
  endtask

  task automatic test_random();
    logic [11:0] a;
    logic [31:0] d, exp;
    int lat;
    for (int n = 0; n < 60; n++) begin
      case ($urandom_range(0, 3))
        0: axil_write(12'h020 + 12'(4 * $urandom_range(0, 10)), $urandom);
        1: axil_write(12'h010, $urandom);
        default: begin
          case ($urandom_range(0, 3))
            0: a = 12'h000;
            1: a = 12'h010;
            2: a = 12'h020 + 12'(4 * $urandom_range(0, 10));
            default: a = 12'(4 * $urandom_range(0, 1023));
          endcase
          exp = ref_read(a);
          axil_read(a, int'($urandom_range(0, 2)), d, lat);
          vec++;
          if (d !== exp || lat !== 2) begin
            errs++; $display("FAIL rand_read addr=%h got=%h lat=%0d want=%h lat=2", a, d, lat, exp);
          end
        end
      endcase
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) bram[i] = 32'h0;
    tap_Do = 32'h0;
    axil.awvalid = 1'b0; axil.wvalid = 1'b0; axil.arvalid = 1'b0; axil.rready = 1'b0;
    axil.awaddr = '0; axil.wdata = '0; axil.araddr = '0;
    eng_tap_en = 1'b0; eng_tap_idx = '0; eng_done = 1'b0;
    foreach (ref_tap[i]) ref_tap[i] = 0;
    test_reset();
    test_taps();
    test_conflict();
    test_taps();
    test_run();
    test_reset_busy();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end
endmodule
